// File: rtl/seg7_pkg.sv
// Shared types, glyph table and nibble-to-glyph helper for the seven-segment scan driver.
// Glyphs are stored active-low as {g,f,e,d,c,b,a}; consumers invert for active-high boards.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble decoder: glyph lookup, blanking override and output polarity.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    seg_t pattern;

    always_comb begin
        pattern = blank ? SEG_OFF : hex_glyph(nibble);
        seg     = ACTIVE_LOW ? pattern : ~pattern;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with tear-free frame-boundary commits and leading-zero blanking.
// Optional per-digit blinking is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     digit_en
);

    localparam int VALUE_W = 4 * NUM_DIGITS;
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam seg_t                  SEG_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [VALUE_W-1:0]    shadow_reg;
    logic                  pending_reg;
    logic [VALUE_W-1:0]    display_reg;
    logic [DIV_W-1:0]      div_cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    seg_t                  seg_reg;
    logic [NUM_DIGITS-1:0] digit_en_reg;

    logic                  digit_end;
    logic                  frame_end;
    logic [3:0]            nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] idx_onehot;
    logic                  blink_blank;
    logic                  blank_cur;
    seg_t                  seg_next;
    logic [NUM_DIGITS-1:0] digit_en_next;

    assign digit_end = (div_cnt_reg == DIV_LAST);
    assign frame_end = digit_end && (idx_reg == IDX_LAST);

    // A digit is a leading zero when it and every more-significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibbles[gi]    = display_reg[4*gi +: 4];
            assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
            if (gi == 0) begin : g_first
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = ~|display_reg[VALUE_W-1:4*gi];
            end
        end
    endgenerate

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
            end
        end
    end

    assign blink_blank = blink_phase_reg && blink_mask[idx_reg];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_blank       = 1'b0;
`endif

    assign blank_cur = (blank_lz && lz_blank[idx_reg]) || blink_blank;

    seg7_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .nibble (nibbles[idx_reg]),
        .blank  (blank_cur),
        .seg    (seg_next)
    );

    assign digit_en_next = ACTIVE_LOW ? ~idx_onehot : idx_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
        end else if (digit_end) begin
            div_cnt_reg <= '0;
            idx_reg     <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // A load landing on the frame boundary bypasses the shadow so it is not delayed a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
            display_reg <= '0;
        end else if (load && frame_end) begin
            shadow_reg  <= value;
            display_reg <= value;
            pending_reg <= 1'b0;
        end else if (load) begin
            shadow_reg  <= value;
            pending_reg <= 1'b1;
        end else if (frame_end && pending_reg) begin
            display_reg <= shadow_reg;
            pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg      <= SEG_IDLE;
            digit_en_reg <= EN_IDLE;
        end else begin
            seg_reg      <= seg_next;
            digit_en_reg <= digit_en_next;
        end
    end

    assign seg      = seg_reg;
    assign digit_en = digit_en_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (6 digits, 4 cycles per digit, blink every 2 frames).
module tb_seg7_scan_driver;

    localparam logic [6:0] G_0   = 7'h40;
    localparam logic [6:0] G_1   = 7'h79;
    localparam logic [6:0] G_F   = 7'h0E;
    localparam logic [6:0] G_OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] value;
    logic        load;
    logic        blank_lz;
    logic [5:0]  blink_mask;
    logic [6:0]  seg;
    logic [5:0]  digit_en;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (4),
        .BLINK_DIV  (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg        (seg),
        .digit_en   (digit_en)
    );

    always #5 clk = ~clk;

    // Advance to just after a given edge number (edges counted from reset release).
    task automatic wait_edge(input int target);
        while (ecount < target) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (seg !== G_OFF) begin n_fail++; $display("FAIL reset_seg seg=%h expected %h", seg, G_OFF); end
        n_checks++;
        if (digit_en !== 6'h3F) begin n_fail++; $display("FAIL reset_en digit_en=%h expected 3f", digit_en); end
        rst = 1'b0;
        ecount = 0;
        n_checks++;
        if (digit_en !== 6'h3F || seg !== G_OFF) begin
            n_fail++; $display("FAIL release_hold seg=%h digit_en=%h expected 7f/3f", seg, digit_en);
        end
        wait_edge(1);
        n_checks++;
        if (digit_en !== 6'h3E || seg !== G_0) begin
            n_fail++; $display("FAIL first_digit seg=%h digit_en=%h expected 40/3e", seg, digit_en);
        end
        $display("reset: seg=%h digit_en=%h", seg, digit_en);
    endtask

    task automatic test_scan;
        logic [5:0] exp_en;
        int d;
        for (int e = 1; e <= 28; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            exp_en = ~(6'b000001 << d);
            n_checks++;
            if (digit_en !== exp_en || seg !== G_0) begin
                n_fail++; $display("FAIL scan e=%0d seg=%h digit_en=%h expected %h/%h", e, seg, digit_en, G_0, exp_en);
            end
        end
        $display("scan: 28 cycles checked");
    endtask

    task automatic test_tear_free;
        logic [6:0] exp_tf [6];
        logic [5:0] exp_en;
        int d;
        exp_tf = '{7'h08, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        wait_edge(57);
        value = 24'h12345A; load = 1'b1;
        wait_edge(58);
        load = 1'b0;
        for (int e = 58; e <= 72; e++) begin
            wait_edge(e);
            n_checks++;
            if (seg !== G_0) begin n_fail++; $display("FAIL tear_old e=%0d seg=%h expected %h", e, seg, G_0); end
        end
        for (int e = 73; e <= 96; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            exp_en = ~(6'b000001 << d);
            n_checks++;
            if (seg !== exp_tf[d] || digit_en !== exp_en) begin
                n_fail++; $display("FAIL tear_new e=%0d seg=%h digit_en=%h expected %h/%h", e, seg, digit_en, exp_tf[d], exp_en);
            end
        end
        $display("tear_free: load 12345a committed at frame boundary");
    endtask

    task automatic test_load_at_frame_end;
        logic [6:0] exp_seg;
        int d;
        wait_edge(119);
        value = 24'h00000F; load = 1'b1;
        wait_edge(120);
        value = 24'h000001;
        wait_edge(121);
        load = 1'b0;
        for (int e = 121; e <= 168; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            exp_seg = (d != 0) ? G_0 : ((e <= 144) ? G_F : G_1);
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL frame_end_load e=%0d seg=%h expected %h", e, seg, exp_seg); end
        end
        $display("load_at_frame_end: F then 1");
    endtask

    task automatic test_blanking;
        logic [6:0] exp_seg;
        int d;
        blank_lz = 1'b1;
        value = 24'h00000F; load = 1'b1;
        wait_edge(169);
        load = 1'b0;
        for (int e = 193; e <= 216; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            exp_seg = (d == 0) ? G_F : G_OFF;
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL blank_f e=%0d seg=%h expected %h", e, seg, exp_seg); end
        end
        value = 24'h000000; load = 1'b1;
        wait_edge(217);
        load = 1'b0;
        for (int e = 241; e <= 264; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            exp_seg = (d == 0) ? G_0 : G_OFF;
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL blank_zero e=%0d seg=%h expected %h", e, seg, exp_seg); end
        end
        value = 24'h0F0000; load = 1'b1;
        wait_edge(265);
        load = 1'b0;
        for (int e = 289; e <= 312; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            exp_seg = (d == 5) ? G_OFF : ((d == 4) ? G_F : G_0);
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL blank_mid e=%0d seg=%h expected %h", e, seg, exp_seg); end
        end
        blank_lz = 1'b0;
        $display("blanking: 00000f, 000000, 0f0000 checked");
    endtask

    task automatic test_reset_midframe;
        value = 24'h12345A; load = 1'b1;
        wait_edge(313);
        load = 1'b0;
        wait_edge(320);
        rst = 1'b1;
        wait_edge(322);
        n_checks++;
        if (seg !== G_OFF || digit_en !== 6'h3F) begin
            n_fail++; $display("FAIL midframe_rst seg=%h digit_en=%h expected 7f/3f", seg, digit_en);
        end
        blink_mask = 6'b000001;
        rst = 1'b0;
        ecount = 0;
        for (int e = 1; e <= 48; e++) begin
            wait_edge(e);
            n_checks++;
            if (seg !== G_0) begin n_fail++; $display("FAIL midframe_discard e=%0d seg=%h expected %h", e, seg, G_0); end
        end
        $display("reset_midframe: pending and display discarded");
    endtask

    task automatic test_blink;
        logic [6:0] exp_seg;
        int d;
        int f;
        for (int e = 49; e <= 144; e++) begin
            wait_edge(e);
            d = ((e - 1) / 4) % 6;
            f = (e - 1) / 24;
            exp_seg = G_0;
`ifdef SEG7_BLINK_EN
            if (d == 0 && ((f / 2) % 2) == 1) exp_seg = G_OFF;
`endif
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL blink e=%0d frame=%0d digit=%0d seg=%h expected %h", e, f, d, seg, exp_seg);
            end
        end
        $display("blink: frames 2..5 checked");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_load_at_frame_end();
        test_blanking();
        test_reset_midframe();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
